cim_macro_arbiter: RTL and testbench

- Shares the single CIM core macro port among NumReq requesters: core data port, DMA, Top_Ctrl sequencer and a spare.
- Sits between the requester ports and the CIM_Core_macro slave window.
- Round-robin arbitration with optional burst lock, stable stall handling, and fixed-latency response routing back to the originating requester.

---
 rtl/cim_macro_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_cim_macro_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cim_macro_arbiter.sv
// cim_macro_arbiter: shares the CIM core macro port among requesters.
// Round-robin with burst lock, stall hold and fixed-latency responses.
module cim_macro_arbiter #(
  parameter int NumReq      = 4,
  parameter int AddrWidth   = 32,
  parameter int DataWidth   = 64,
  parameter int RespLatency = 2,
  parameter int MaxLock     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NumReq-1:0]             req_i,
  input  logic [NumReq-1:0]             we_i,
  input  logic [NumReq-1:0]             lock_i,
  input  logic [NumReq*AddrWidth-1:0]   addr_i,
  input  logic [NumReq*DataWidth-1:0]   wdata_i,
  input  logic [NumReq*DataWidth/8-1:0] be_i,
  output logic [NumReq-1:0]             gnt_o,
  output logic [NumReq-1:0]             rvalid_o,
  output logic [DataWidth-1:0]          rdata_o,
  output logic                          macro_req_o,
  output logic                          macro_we_o,
  output logic [AddrWidth-1:0]          macro_addr_o,
  output logic [DataWidth-1:0]          macro_wdata_o,
  output logic [DataWidth/8-1:0]        macro_be_o,
  input  logic                          macro_ready_i,
  input  logic [DataWidth-1:0]          macro_rdata_i
);

  localparam int BeW  = DataWidth / 8;
  localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxLock + 1);

  // arbitration state
  logic [IdW-1:0]  r_rr_ptr;
  logic            r_pending;
  logic [IdW-1:0]  r_pending_sel;
  logic            r_lock_vld;
  logic [IdW-1:0]  r_lock_owner;
  logic [CntW-1:0] r_lock_cnt;

  // response pipe: stage 0 is the newest accept
  logic [RespLatency-1:0]          r_pipe_vld;
  logic [RespLatency-1:0][IdW-1:0] r_pipe_id;
  logic [RespLatency-1:0]          r_pipe_rd;

  logic [IdW-1:0] w_rr_sel;
  logic           w_lock_hit;
  logic [IdW-1:0] w_sel;
  logic           w_macro_req;
  logic           w_acc;
  logic [IdW-1:0] w_next_ptr;
  logic           w_out_vld;
  logic [IdW-1:0] w_out_id;

  // round-robin search starting at the pointer
  always_comb begin
    int idx;
    logic found;
    w_rr_sel = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < NumReq; i++) begin
      idx = (int'(r_rr_ptr) + i) % NumReq;
      if (!found && req_i[idx]) begin
        w_rr_sel = IdW'(idx);
        found    = 1'b1;
      end
    end
  end

  // lock owner keeps priority while requesting and under the cap
  always_comb begin
    w_lock_hit = r_lock_vld
               && req_i[r_lock_owner]
               && (r_lock_cnt < CntW'(MaxLock));
  end

  // final select: stalled request, then lock, then round-robin
  always_comb begin
    w_sel = w_rr_sel;
    if (r_pending) begin
      w_sel = r_pending_sel;
    end else if (w_lock_hit) begin
      w_sel = r_lock_owner;
    end
  end

  // handshake and pointer successor
  always_comb begin
    w_macro_req = rst_ni & (|req_i);
    w_acc       = w_macro_req & macro_ready_i;
    w_next_ptr  = IdW'((int'(w_sel) + 1) % NumReq);
  end

  // macro-side payload mux, zero when idle or in reset
  always_comb begin
    macro_req_o   = w_macro_req;
    macro_we_o    = 1'b0;
    macro_addr_o  = '0;
    macro_wdata_o = '0;
    macro_be_o    = '0;
    if (w_macro_req) begin
      macro_we_o    = we_i[w_sel];
      macro_addr_o  = addr_i[w_sel*AddrWidth +: AddrWidth];
      macro_wdata_o = wdata_i[w_sel*DataWidth +: DataWidth];
      macro_be_o    = be_i[w_sel*BeW +: BeW];
    end
  end

  // grant is combinational on ready, only in the accept cycle
  always_comb begin
    gnt_o = '0;
    if (w_acc) begin
      gnt_o[w_sel] = 1'b1;
    end
  end

  // response routing from the pipe output
  always_comb begin
    w_out_vld = rst_ni & r_pipe_vld[RespLatency-1];
    w_out_id  = r_pipe_id[RespLatency-1];
    rvalid_o  = '0;
    rdata_o   = '0;
    if (w_out_vld) begin
      rvalid_o[w_out_id] = 1'b1;
      if (r_pipe_rd[RespLatency-1]) begin
        rdata_o = macro_rdata_i;
      end
    end
  end

  // pointer and stall tracking
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rr_ptr      <= '0;
      r_pending     <= 1'b0;
      r_pending_sel <= '0;
    end else if (w_acc) begin
      r_rr_ptr  <= w_next_ptr;
      r_pending <= 1'b0;
    end else if (w_macro_req) begin
      r_pending     <= 1'b1;
      r_pending_sel <= w_sel;
    end
  end

  // burst lock owner and consecutive-grant count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_lock_vld   <= 1'b0;
      r_lock_owner <= '0;
      r_lock_cnt   <= '0;
    end else if (w_acc) begin
      if (lock_i[w_sel]) begin
        r_lock_vld   <= 1'b1;
        r_lock_owner <= w_sel;
        if (r_lock_vld && (r_lock_owner == w_sel)
            && (r_lock_cnt < CntW'(MaxLock))) begin
          r_lock_cnt <= r_lock_cnt + 1'b1;
        end else begin
          r_lock_cnt <= CntW'(1);
        end
      end else begin
        r_lock_vld <= 1'b0;
        r_lock_cnt <= '0;
      end
    end
  end

  // fixed-latency response pipe, shifts every cycle
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_pipe_vld <= '0;
      r_pipe_id  <= '0;
      r_pipe_rd  <= '0;
    end else begin
      r_pipe_vld[0] <= w_acc;
      r_pipe_id[0]  <= w_sel;
      r_pipe_rd[0]  <= ~we_i[w_sel];
      for (int i = 1; i < RespLatency; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_id[i]  <= r_pipe_id[i-1];
        r_pipe_rd[i]  <= r_pipe_rd[i-1];
      end
    end
  end

endmodule

// File: tb/tb_cim_macro_arbiter.sv
// tb_cim_macro_arbiter: scoreboard bench with directed and random traffic.
// Grants checked per cycle against a model; responses by a monitor.
module tb_cim_macro_arbiter;
  localparam int N   = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int BW  = DW / 8;
  localparam int LAT = 2;
  localparam int ML  = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [N-1:0] req, we, lock;
  logic [N*AW-1:0] addr_p;
  logic [N*DW-1:0] wdata_p;
  logic [N*BW-1:0] be_p;
  logic [N-1:0] gnt_o, rvalid_o;
  logic [DW-1:0] rdata_o;
  logic macro_req_o, macro_we_o;
  logic [AW-1:0] macro_addr_o;
  logic [DW-1:0] macro_wdata_o;
  logic [BW-1:0] macro_be_o;
  logic ready;
  logic [DW-1:0] mrdata;

  cim_macro_arbiter #(
    .NumReq(N), .AddrWidth(AW), .DataWidth(DW),
    .RespLatency(LAT), .MaxLock(ML)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_i(req), .we_i(we), .lock_i(lock),
    .addr_i(addr_p), .wdata_i(wdata_p), .be_i(be_p),
    .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
    .macro_req_o(macro_req_o), .macro_we_o(macro_we_o),
    .macro_addr_o(macro_addr_o), .macro_wdata_o(macro_wdata_o),
    .macro_be_o(macro_be_o), .macro_ready_i(ready),
    .macro_rdata_i(mrdata)
  );

  always #5 clk = ~clk;

  // next-cycle stimulus
  logic [N-1:0] nreq, nwe, nlock;
  logic nready, nrst;
  logic [AW-1:0] a[N];
  logic [DW-1:0] wd[N];
  logic [BW-1:0] b[N];

  typedef struct {
    int id;
    bit rd;
    int due;
  } exp_t;
  exp_t q[$];

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model state
  int m_rr = 0;
  bit m_pend = 0;
  int m_psel = 0;
  int m_lown = -1;
  int m_lcnt = 0;
  int lastacc = -1;

  logic [N-1:0] d_gnt, d_rv;
  logic d_mreq, d_mwe;
  logic [BW-1:0] d_mbe;
  logic [AW-1:0] d_maddr;
  logic [DW-1:0] d_rd;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic int pick();
    if (m_pend) return m_psel;
    if (m_lown >= 0 && nreq[m_lown] && m_lcnt < ML) return m_lown;
    for (int i = 0; i < N; i++) begin
      if (nreq[(m_rr + i) % N]) return (m_rr + i) % N;
    end
    return -1;
  endfunction

  task automatic step();
    int s;
    bit acc;
    logic [N-1:0] eg;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      addr_p[i*AW +: AW]  = a[i];
      wdata_p[i*DW +: DW] = wd[i];
      be_p[i*BW +: BW]    = b[i];
    end
    req    = nreq;
    we     = nwe;
    lock   = nlock;
    ready  = nready;
    rst_n  = nrst;
    mrdata = {$urandom, $urandom};
    #4;
    d_gnt   = gnt_o;
    d_rv    = rvalid_o;
    d_rd    = rdata_o;
    d_mreq  = macro_req_o;
    d_mwe   = macro_we_o;
    d_mbe   = macro_be_o;
    d_maddr = macro_addr_o;
    if (!nrst) begin
      chk("rst_gnt", gnt_o, 0);
      chk("rst_macro", {macro_req_o, macro_we_o, macro_be_o,
                        macro_addr_o, macro_wdata_o}, 0);
      m_rr = 0; m_pend = 0; m_lown = -1; m_lcnt = 0;
      lastacc = -1;
      q.delete();
    end else begin
      s   = pick();
      acc = (s >= 0) && nready;
      eg  = '0;
      if (acc) eg[s] = 1'b1;
      chk("gnt", gnt_o, eg);
      chk("macro_req", macro_req_o, s >= 0);
      if (s >= 0)
        chk("payload", {macro_we_o, macro_be_o, macro_addr_o,
                        macro_wdata_o}, {nwe[s], b[s], a[s], wd[s]});
      else
        chk("payload_idle", {macro_we_o, macro_be_o, macro_addr_o,
                             macro_wdata_o}, 0);
      lastacc = acc ? s : -1;
      if (acc) begin
        q.push_back('{s, !nwe[s], cyc + LAT});
        m_rr = (s + 1) % N;
        m_pend = 0;
        if (nlock[s]) begin
          m_lcnt = (m_lown == s && m_lcnt < ML) ? m_lcnt + 1 : 1;
          m_lown = s;
        end else begin
          m_lown = -1;
          m_lcnt = 0;
        end
      end else if (s >= 0) begin
        m_pend = 1;
        m_psel = s;
      end
    end
  endtask

  // response monitor
  initial begin
    exp_t e;
    logic [N-1:0] ev;
    forever begin
      @(posedge clk);
      #7;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        ev = '0;
        ev[e.id] = 1'b1;
        chk("rvalid", rvalid_o, ev);
        chk("rdata", rdata_o, e.rd ? mrdata : '0);
      end else begin
        chk("rvalid_idle", rvalid_o, 0);
        chk("rdata_idle", rdata_o, 0);
      end
    end
  end

  initial begin
    int lock_exp[10];
    lock_exp = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    rst_n = 1'b0; req = '0; we = '0; lock = '0; ready = 1'b0;
    addr_p = '0; wdata_p = '0; be_p = '0; mrdata = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = 32'h1000_0000 + 32'(i * 16);
      wd[i] = {$urandom, $urandom};
      b[i] = 8'hFF;
    end
    nwe = '0; nlock = '0;

    // reset with every requester active
    nrst = 1'b0; nreq = '1; nready = 1'b1;
    step();
    step();
    chk("rst_gnt_d", d_gnt, 0);
    chk("rst_mreq_d", d_mreq, 0);
    chk("rst_rv_d", {d_rv, d_rd}, 0);
    nrst = 1'b1;
    step();
    chk("first_gnt", d_gnt, 4'b0001);
    for (int k = 1; k <= 4; k++) begin
      step();
      chk("rr_order", d_gnt, 4'b0001 << (k % N));
    end

    // stall holds the macro request stable
    nreq = '0;
    repeat (3) step();
    nreq[2] = 1'b1; a[2] = 32'h3000_0040; nready = 1'b0;
    step();
    chk("stall_addr0", d_maddr, 32'h3000_0040);
    nreq[0] = 1'b1;
    step();
    chk("stall_addr1", d_maddr, 32'h3000_0040);
    chk("stall_nognt", d_gnt, 0);
    step();
    chk("stall_addr2", d_maddr, 32'h3000_0040);
    nready = 1'b1;
    step();
    chk("stall_gnt2", d_gnt, 4'b0100);
    nreq[2] = 1'b0;
    step();
    chk("stall_gnt0", d_gnt, 4'b0001);
    nreq[0] = 1'b0;

    // burst lock capped at MaxLock
    nreq[0] = 1'b1; nreq[1] = 1'b1; nlock[1] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("lock_order", d_gnt, 4'b0001 << lock_exp[k]);
    end
    nreq = '0; nlock = '0;

    // write response carries zero data
    nreq[3] = 1'b1; nwe[3] = 1'b1; b[3] = 8'h0F;
    step();
    chk("wr_gnt", d_gnt, 4'b1000);
    chk("wr_we_be", {d_mwe, d_mbe}, {1'b1, 8'h0F});
    nreq[3] = 1'b0; nwe[3] = 1'b0;
    repeat (3) step();

    // reset one cycle after a read accept drops it
    nreq[1] = 1'b1;
    step();
    chk("pre_rst_gnt", d_gnt, 4'b0010);
    nreq[1] = 1'b0; nrst = 1'b0;
    step();
    nrst = 1'b1; nreq = '1;
    step();
    chk("post_rst_gnt", d_gnt, 4'b0001);
    chk("post_rst_rv", d_rv, 0);
    nreq = '0;
    repeat (3) step();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!nreq[i] || lastacc == i) begin
          nreq[i]  = ($urandom_range(0, 99) < 45);
          nwe[i]   = 1'($urandom_range(0, 1));
          nlock[i] = ($urandom_range(0, 99) < 35);
          a[i]     = $urandom;
          wd[i]    = {$urandom, $urandom};
          b[i]     = 8'($urandom);
        end
      end
      nready = ($urandom_range(0, 99) < 70);
      nrst   = ($urandom_range(0, 299) != 0);
      step();
    end
    nreq = '0; nrst = 1'b1;
    repeat (LAT + 3) step();
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
